// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the SPI memory-controller arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_e;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_D  = 1'b1
   } gnt_e;

   localparam int unsigned WORD_BYTES         = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 4095;

   // Out-of-range byte counts fall back to a full word.
   function automatic logic [3:0] clamp_bytes(input logic [3:0] b);
      return ((b == 4'd0) || (b > 4'(WORD_BYTES))) ? 4'(WORD_BYTES) : b;
   endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Clearable, enabled up-counter flagging LIMIT enabled cycles; LIMIT of 0 disables it.
module mem_arb_timer
   import mem_arb_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc_c
);

   localparam int unsigned CNT_W = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (LIMIT != 0)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires during the LIMIT-th enabled cycle.
   assign tc_c = (LIMIT != 0) && en && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the fetch and data ports onto one SPI memory controller,
// with a starvation bound for fetch and a hung-transaction timeout.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W         = 24,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned DATA_MAX_RUN   = 2,
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [3:0]        d_bytes,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mc_start,
   output logic [ADDR_W-1:0] mc_addr,
   output logic              mc_is_data,
   output logic [3:0]        mc_read_bytes,
   input  logic              mc_done,
   input  logic [DATA_W-1:0] mc_instr,
   input  logic [DATA_W-1:0] mc_data,
   output logic              busy,
   output logic              err
);

   localparam int unsigned RUN_W = (DATA_MAX_RUN < 1) ? 1 : $clog2(DATA_MAX_RUN + 1);

   state_e            state_q, state_d;
   gnt_e              gnt_q, gnt_d;
   logic [RUN_W-1:0]  run_q, run_d;
   logic              mc_start_q, mc_start_d;
   logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
   logic              mc_is_data_q, mc_is_data_d;
   logic [3:0]        mc_read_bytes_q, mc_read_bytes_d;
   logic              if_ack_q, if_ack_d;
   logic              d_ack_q, d_ack_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
   logic              busy_q, busy_d;
   logic              err_q, err_d;

   logic if_elig, d_elig, pick_d, run_full, timeout_c;

   mem_arb_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
      .clk  (clk),
      .rst  (rst),
      .clr  (state_q != BUSY),
      .en   (state_q == BUSY),
      .tc_c (timeout_c)
   );

   // A requester acked this cycle is still holding req; keep it out of the next pick.
   assign if_elig  = if_req && !if_ack_q;
   assign d_elig   = d_req && !d_ack_q;
   assign run_full = (run_q == RUN_W'(DATA_MAX_RUN));
   assign pick_d   = d_elig && !(if_elig && run_full);

   always_comb begin
      state_d         = state_q;
      gnt_d           = gnt_q;
      run_d           = run_q;
      mc_start_d      = mc_start_q;
      mc_addr_d       = mc_addr_q;
      mc_is_data_d    = mc_is_data_q;
      mc_read_bytes_d = mc_read_bytes_q;
      if_ack_d        = 1'b0;
      d_ack_d         = 1'b0;
      if_rdata_d      = if_rdata_q;
      d_rdata_d       = d_rdata_q;
      busy_d          = busy_q;
      err_d           = err_q;

      unique case (state_q)
         IDLE: begin
            if (if_elig || d_elig) begin
               gnt_d           = pick_d ? GNT_D : GNT_IF;
               mc_addr_d       = pick_d ? d_addr : if_addr;
               mc_is_data_d    = pick_d;
               mc_read_bytes_d = pick_d ? clamp_bytes(d_bytes) : 4'(WORD_BYTES);
               run_d           = (pick_d && if_req) ? (run_full ? run_q : run_q + RUN_W'(1))
                                                    : '0;
               mc_start_d      = 1'b1;
               busy_d          = 1'b1;
               state_d         = BUSY;
            end
         end
         BUSY: begin
            // Completion takes priority over a coincident timeout.
            if (mc_done) begin
               if (gnt_q == GNT_D) d_rdata_d  = mc_data;
               else                if_rdata_d = mc_instr;
               mc_start_d = 1'b0;
               state_d    = RELEASE;
            end else if (timeout_c) begin
               if (gnt_q == GNT_D) d_rdata_d  = '0;
               else                if_rdata_d = '0;
               err_d      = 1'b1;
               mc_start_d = 1'b0;
               state_d    = RELEASE;
            end
         end
         RELEASE: begin
            if_ack_d = (gnt_q == GNT_IF);
            d_ack_d  = (gnt_q == GNT_D);
            busy_d   = 1'b0;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         gnt_q           <= GNT_IF;
         run_q           <= '0;
         mc_start_q      <= 1'b0;
         mc_addr_q       <= '0;
         mc_is_data_q    <= 1'b0;
         mc_read_bytes_q <= '0;
         if_ack_q        <= 1'b0;
         d_ack_q         <= 1'b0;
         if_rdata_q      <= '0;
         d_rdata_q       <= '0;
         busy_q          <= 1'b0;
         err_q           <= 1'b0;
      end else begin
         state_q         <= state_d;
         gnt_q           <= gnt_d;
         run_q           <= run_d;
         mc_start_q      <= mc_start_d;
         mc_addr_q       <= mc_addr_d;
         mc_is_data_q    <= mc_is_data_d;
         mc_read_bytes_q <= mc_read_bytes_d;
         if_ack_q        <= if_ack_d;
         d_ack_q         <= d_ack_d;
         if_rdata_q      <= if_rdata_d;
         d_rdata_q       <= d_rdata_d;
         busy_q          <= busy_d;
         err_q           <= err_d;
      end
   end

   assign mc_start      = mc_start_q;
   assign mc_addr       = mc_addr_q;
   assign mc_is_data    = mc_is_data_q;
   assign mc_read_bytes = mc_read_bytes_q;
   assign if_ack        = if_ack_q;
   assign d_ack         = d_ack_q;
   assign if_rdata      = if_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign busy          = busy_q;
   assign err           = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter; the bench also plays the memory controller.
module tb_mem_arbiter;

   localparam int unsigned AW     = 24;
   localparam int unsigned DW     = 32;
   localparam int          MAXRUN = 2;
   localparam int          TO     = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, mc_done;
   logic [AW-1:0] if_addr, d_addr;
   logic [3:0]    d_bytes;
   logic [DW-1:0] mc_instr, mc_data;
   logic          if_ack, d_ack, mc_start, mc_is_data, busy, err;
   logic [DW-1:0] if_rdata, d_rdata;
   logic [AW-1:0] mc_addr;
   logic [3:0]    mc_read_bytes;

   mem_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .DATA_MAX_RUN(MAXRUN), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_addr(d_addr), .d_bytes(d_bytes), .d_ack(d_ack), .d_rdata(d_rdata),
      .mc_start(mc_start), .mc_addr(mc_addr), .mc_is_data(mc_is_data),
      .mc_read_bytes(mc_read_bytes), .mc_done(mc_done), .mc_instr(mc_instr),
      .mc_data(mc_data), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            run_m;
   bit            err_m;
   logic [DW-1:0] if_rdata_m, d_rdata_m;
   bit            grant_due, due_d, held_prev, prev_d;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [3:0] exp_bytes(input logic [3:0] b);
      if (b >= 4'd1 && b <= 4'd4) return b;
      return 4'd4;
   endfunction

   function automatic int next_run(input bit data_won, input bit if_line, input int r);
      if (data_won && if_line) return (r < MAXRUN) ? r + 1 : r;
      return 0;
   endfunction

   // One transaction: request, grant, controller response, release, ack, mask cycle.
   task automatic run_txn(input bit raise_if, input bit raise_d, input logic [AW-1:0] ia,
                          input logic [AW-1:0] da, input logic [3:0] db, input int lat,
                          input logic [DW-1:0] rd, input bit hold_extra, input bit drop_early,
                          input bit raise_other);
      bit            win_d, timed, other_hi, win_hi;
      int            c;
      logic [DW-1:0] exp_rd;
      if (grant_due) begin
         win_d = due_d;
      end else begin
         if (raise_if && !if_req) begin if_req = 1'b1; if_addr = ia; end
         if (raise_d && !d_req) begin d_req = 1'b1; d_addr = da; d_bytes = db; end
         if (!if_req && !d_req) return;
         win_d = d_req && !(if_req && run_m == MAXRUN);
         run_m = next_run(win_d, if_req, run_m);
      end
      @(negedge clk);
      grant_due = 1'b0;
      if (held_prev) begin
         if (prev_d) d_req = 1'b0; else if_req = 1'b0;
         held_prev = 1'b0;
      end
      check("grant_start", 32'(mc_start), 32'(1));
      check("grant_is_data", 32'(mc_is_data), 32'(win_d));
      check("grant_addr", 32'(mc_addr), 32'(win_d ? d_addr : if_addr));
      check("grant_bytes", 32'(mc_read_bytes), 32'(win_d ? exp_bytes(d_bytes) : 4'd4));
      check("grant_busy", 32'(busy), 32'(1));

      c = 1; timed = 1'b0; exp_rd = '0;
      forever begin
         if (c > 1) check("busy_start", 32'(mc_start), 32'(1));
         if (drop_early && c == 1) begin
            if (win_d) d_req = 1'b0; else if_req = 1'b0;
         end
         mc_instr = $urandom;
         mc_data  = $urandom;
         if (c == lat) begin
            mc_done = 1'b1;
            if (win_d) mc_data = rd; else mc_instr = rd;
            exp_rd = rd;
            break;
         end
         if (c == TO) begin
            timed = 1'b1;
            break;
         end
         @(negedge clk);
         c++;
      end

      @(negedge clk);
      mc_done = 1'($urandom);
      if (timed) err_m = 1'b1;
      if (win_d) d_rdata_m = exp_rd; else if_rdata_m = exp_rd;
      check("rel_start", 32'(mc_start), 32'(0));
      check("rel_busy", 32'(busy), 32'(1));
      check("rel_if_ack", 32'(if_ack), 32'(0));
      check("rel_d_ack", 32'(d_ack), 32'(0));
      check("rel_err", 32'(err), 32'(err_m));

      @(negedge clk);
      mc_done = 1'b0;
      check("ack_if", 32'(if_ack), 32'(!win_d));
      check("ack_d", 32'(d_ack), 32'(win_d));
      check("ack_if_rdata", if_rdata, if_rdata_m);
      check("ack_d_rdata", d_rdata, d_rdata_m);
      check("ack_start", 32'(mc_start), 32'(0));
      check("ack_busy", 32'(busy), 32'(0));
      check("ack_err", 32'(err), 32'(err_m));

      if (!hold_extra) begin
         if (win_d) d_req = 1'b0; else if_req = 1'b0;
      end
      if (raise_other) begin
         if (win_d && !if_req) begin
            if_req = 1'b1; if_addr = AW'($urandom);
         end else if (!win_d && !d_req) begin
            d_req = 1'b1; d_addr = AW'($urandom); d_bytes = 4'($urandom);
         end
      end
      other_hi = win_d ? if_req : d_req;
      win_hi   = win_d ? d_req : if_req;
      if (other_hi) begin
         grant_due = 1'b1;
         due_d     = !win_d;
         run_m     = next_run(due_d, if_req, run_m);
         held_prev = win_hi;
         prev_d    = win_d;
      end else begin
         @(negedge clk);
         check("mask_start", 32'(mc_start), 32'(0));
         check("mask_if_ack", 32'(if_ack), 32'(0));
         check("mask_d_ack", 32'(d_ack), 32'(0));
         if (win_d) d_req = 1'b0; else if_req = 1'b0;
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit ri, rdq;
      rst = 1'b1; if_req = 1'b0; d_req = 1'b0; mc_done = 1'b0;
      if_addr = '0; d_addr = '0; d_bytes = '0; mc_instr = '0; mc_data = '0;
      run_m = 0; err_m = 1'b0; if_rdata_m = '0; d_rdata_m = '0;
      grant_due = 1'b0; due_d = 1'b0; held_prev = 1'b0; prev_d = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_start", 32'(mc_start), 32'(0));
      check("rst_addr", 32'(mc_addr), 32'(0));
      check("rst_is_data", 32'(mc_is_data), 32'(0));
      check("rst_bytes", 32'(mc_read_bytes), 32'(0));
      check("rst_acks", 32'({if_ack, d_ack}), 32'(0));
      check("rst_rdata", if_rdata | d_rdata, 32'(0));
      check("rst_busy_err", 32'({busy, err}), 32'(0));
      rst = 1'b0;
      @(negedge clk);

      run_txn(1, 0, 24'h000010, 24'h0, 4'd0, 5, 32'h00A00093, 0, 0, 0);
      run_txn(0, 1, 24'h0, 24'h000200, 4'd0, 2, $urandom, 0, 0, 0);
      run_txn(0, 1, 24'h0, 24'h000204, 4'd7, 3, $urandom, 0, 0, 0);
      run_txn(0, 1, 24'h0, 24'h000300, 4'd4, 1, 32'hDEADBEEF, 1, 0, 0);
      run_txn(0, 1, 24'h0, 24'h000310, 4'd1, TO, $urandom, 0, 0, 0);
      run_txn(0, 1, 24'h0, 24'h000320, 4'd3, 100, $urandom, 0, 0, 0);
      run_txn(1, 1, 24'h000040, 24'h000100, 4'd2, 2, $urandom, 1, 0, 1);
      for (int i = 0; i < 5; i++)
         run_txn(1, 1, 24'h000040, 24'h000100, 4'd2, 2, $urandom, 1, 0, 1);

      for (int i = 0; i < 80; i++) begin
         ri  = 1'($urandom);
         rdq = ri ? 1'($urandom) : 1'b1;
         run_txn(ri, rdq, AW'($urandom), AW'($urandom), 4'($urandom),
                 int'($urandom_range(10, 1)), $urandom, 1'($urandom),
                 ($urandom_range(7, 0) == 0), 1'($urandom));
      end

      // Asynchronous reset in the middle of a transaction.
      if (!if_req) begin if_req = 1'b1; if_addr = 24'h000ABC; end
      grant_due = 1'b0;
      @(negedge clk);
      check("pre_rst_start", 32'(mc_start), 32'(1));
      #2 rst = 1'b1;
      #1;
      check("arst_start", 32'(mc_start), 32'(0));
      check("arst_acks", 32'({if_ack, d_ack}), 32'(0));
      check("arst_busy_err", 32'({busy, err}), 32'(0));
      check("arst_rdata", if_rdata | d_rdata, 32'(0));
      check("arst_mc", 32'({mc_addr, mc_is_data, mc_read_bytes}), 32'(0));
      @(negedge clk);
      d_req = 1'b0; if_req = 1'b1; if_addr = 24'h000ABC; held_prev = 1'b0;
      run_m = 0; err_m = 1'b0; if_rdata_m = '0; d_rdata_m = '0;
      check("arst_no_ack", 32'({if_ack, d_ack}), 32'(0));
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_start", 32'(mc_start), 32'(1));
      check("post_rst_is_data", 32'(mc_is_data), 32'(0));
      check("post_rst_addr", 32'(mc_addr), 32'(24'h000ABC));
      check("post_rst_err", 32'(err), 32'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
